// File: rtl/alu_arbiter_if.sv
// Bundles the two request/response channels and the ALU hookup for alu_arbiter.
// Valid/ready: a transfer happens on a rising edge where both are high.
interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [2:0]       req0_sel;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [2:0]       req1_sel;

    logic             rsp0_valid;
    logic             rsp0_ready;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp_r;
    logic             rsp_zf;
    logic             rsp_err;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_sel;
    logic [WIDTH-1:0] alu_r;
    logic             alu_zf;

    logic             busy;
    logic [1:0]       dbg_state;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sel,
        input  req1_valid, req1_a, req1_b, req1_sel,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_r, rsp_zf, rsp_err,
        input  rsp0_ready, rsp1_ready,
        output alu_a, alu_b, alu_sel,
        input  alu_r, alu_zf,
        output busy, dbg_state
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_sel,
        output req1_valid, req1_a, req1_b, req1_sel,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_r, rsp_zf, rsp_err,
        output rsp0_ready, rsp1_ready,
        input  alu_a, alu_b, alu_sel,
        output alu_r, alu_zf,
        input  busy, dbg_state
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Optional ALU_ARB_DIVZERO_EN: divide-by-zero answered directly with rsp_err=1.
module alu_arbiter #(
    parameter int WIDTH       = 32,
    parameter int EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES);

    state_t           state_q;
    state_t           state_d;
    logic             last_grant_q;
    logic             owner_q;
    logic [3:0]       cnt_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [2:0]       alu_sel_q;
    logic [WIDTH-1:0] rsp_r_q;
    logic             rsp_zf_q;
    logic             rsp_err_q;
    logic             rsp0_valid_q;
    logic             rsp1_valid_q;

    logic             grant;
    logic             accept;
    logic             capture;
    logic             rsp_done;
    logic             div_zero;
    logic [WIDTH-1:0] win_a;
    logic [WIDTH-1:0] win_b;
    logic [2:0]       win_sel;

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        grant   = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_grant_q;
        end else if (bus.req1_valid) begin
            grant = 1'b1;
        end
        win_a   = grant ? bus.req1_a   : bus.req0_a;
        win_b   = grant ? bus.req1_b   : bus.req0_b;
        win_sel = grant ? bus.req1_sel : bus.req0_sel;
    end

    assign accept   = (state_q == IDLE) && !rst && (bus.req0_valid || bus.req1_valid);
    assign capture  = (state_q == EXEC) && (cnt_q == 4'd1);
    assign rsp_done = (state_q == RESP) && (owner_q ? bus.rsp1_ready : bus.rsp0_ready);

`ifdef ALU_ARB_DIVZERO_EN
    assign div_zero = (win_sel == 3'd6) && (win_b == '0);
`else
    assign div_zero = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)   state_d = div_zero ? RESP : EXEC;
            EXEC:    if (capture)  state_d = RESP;
            RESP:    if (rsp_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            cnt_q        <= 4'd0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= 3'd0;
            rsp_r_q      <= '0;
            rsp_zf_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
        end else if (accept) begin
            owner_q      <= grant;
            last_grant_q <= grant;
            if (div_zero) begin
                // Answered without touching the ALU; response is up next cycle.
                cnt_q        <= 4'd0;
                rsp_r_q      <= '1;
                rsp_zf_q     <= 1'b0;
                rsp_err_q    <= 1'b1;
                rsp0_valid_q <= ~grant;
                rsp1_valid_q <= grant;
            end else begin
                cnt_q     <= CNT_LOAD;
                alu_a_q   <= win_a;
                alu_b_q   <= win_b;
                alu_sel_q <= win_sel;
            end
        end else if (state_q == EXEC) begin
            cnt_q <= cnt_q - 4'd1;
            if (capture) begin
                rsp_r_q      <= bus.alu_r;
                rsp_zf_q     <= bus.alu_zf;
                rsp_err_q    <= 1'b0;
                rsp0_valid_q <= ~owner_q;
                rsp1_valid_q <= owner_q;
            end
        end else if (rsp_done) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
        end
    end

    assign bus.req0_ready = accept && !grant;
    assign bus.req1_ready = accept && grant;
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp_r      = rsp_r_q;
    assign bus.rsp_zf     = rsp_zf_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_sel    = alu_sel_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter with a transaction-level model
// and a behavioural ALU; honours ALU_ARB_DIVZERO_EN when defined.
module tb_alu_arbiter;
    localparam int W  = 32;
    localparam int EC = 3;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    bit   model_last;
    logic [W-1:0] exp_q[$];

    alu_arbiter_if #(.WIDTH(W)) bus();

    alu_arbiter #(.WIDTH(W), .EXEC_CYCLES(EC)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] sel);
        case (sel)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            3'd5: return a * b;
            3'd6: return (b == '0) ? W'(0) : a / b;
            default: return b;
        endcase
    endfunction

    function automatic bit is_dz(input logic [W-1:0] b, input logic [2:0] sel);
`ifdef ALU_ARB_DIVZERO_EN
        return (sel == 3'd6) && (b == '0);
`else
        return 1'b0;
`endif
    endfunction

    assign bus.alu_r  = alu_fn(bus.alu_a, bus.alu_b, bus.alu_sel);
    assign bus.alu_zf = (bus.alu_r == '0);

    task automatic drive_idle();
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_sel = 3'd0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_sel = 3'd0;
        bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    endtask

    // Leaves time at posedge+1 with reset released and the DUT idle.
    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        #1;
        bus.req0_valid = 1'b1;
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0 ||
            bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: busy=%b v0=%b v1=%b r0=%b r1=%b want all 0",
                     bus.busy, bus.rsp0_valid, bus.rsp1_valid, bus.req0_ready, bus.req1_ready);
        end
        total++;
        if (bus.rsp_r !== '0 || bus.rsp_zf !== 1'b0 || bus.rsp_err !== 1'b0 ||
            bus.alu_a !== '0 || bus.alu_b !== '0 || bus.alu_sel !== 3'd0) begin
            bad++;
            $display("FAIL reset_data: r=%h zf=%b err=%b a=%h b=%h sel=%0d want all 0",
                     bus.rsp_r, bus.rsp_zf, bus.rsp_err, bus.alu_a, bus.alu_b, bus.alu_sel);
        end
        bus.req0_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_last = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    // One full transaction, starting at posedge+1 with the DUT idle.
    task automatic do_txn(input bit v0, input bit v1,
                          input logic [W-1:0] a0, input logic [W-1:0] b0, input logic [2:0] s0,
                          input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [2:0] s1,
                          input int hold, input bit keep);
        bit win;
        bit dz;
        logic [W-1:0] ea, eb, er;
        logic [2:0] es;
        int edges;
        bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_sel = s0;
        bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_sel = s1;
        #1;
        win = (v0 && v1) ? ~model_last : v1;
        total++;
        if (bus.req0_ready !== ~win || bus.req1_ready !== win) begin
            bad++;
            $display("FAIL grant: ready0=%b ready1=%b want winner req%0d",
                     bus.req0_ready, bus.req1_ready, win);
        end
        ea = win ? a1 : a0;
        eb = win ? b1 : b0;
        es = win ? s1 : s0;
        dz = is_dz(eb, es);
        exp_q.push_back(dz ? {W{1'b1}} : alu_fn(ea, eb, es));
        model_last = win;
        edges = dz ? 0 : EC;

        @(posedge clk); #1;
        if (!keep) begin
            bus.req0_valid = 1'b0;
            bus.req1_valid = 1'b0;
        end
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_after_accept: got %b want 1", bus.busy);
        end
        for (int i = 0; i < edges; i++) begin
            #1;
            total++;
            if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0 ||
                bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 ||
                bus.alu_a !== ea || bus.alu_b !== eb || bus.alu_sel !== es) begin
                bad++;
                $display("FAIL exec%0d: v0=%b v1=%b r0=%b r1=%b alu=%h/%h/%0d want 0 0 0 0 %h/%h/%0d",
                         i, bus.rsp0_valid, bus.rsp1_valid, bus.req0_ready, bus.req1_ready,
                         bus.alu_a, bus.alu_b, bus.alu_sel, ea, eb, es);
            end
            @(posedge clk); #1;
        end

        er = exp_q.pop_front();
        total++;
        if (bus.rsp0_valid !== ~win || bus.rsp1_valid !== win || bus.rsp_r !== er ||
            bus.rsp_zf !== (!dz && er == '0) || bus.rsp_err !== dz) begin
            bad++;
            $display("FAIL response: v0=%b v1=%b r=%h zf=%b err=%b want %b %b %h %b %b",
                     bus.rsp0_valid, bus.rsp1_valid, bus.rsp_r, bus.rsp_zf, bus.rsp_err,
                     ~win, win, er, (!dz && er == '0), dz);
        end

        for (int h = 0; h < hold; h++) begin
            bus.rsp0_ready = win ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.rsp1_ready = win ? 1'b0 : 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            total++;
            if (bus.rsp0_valid !== ~win || bus.rsp1_valid !== win || bus.rsp_r !== er ||
                bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 || bus.busy !== 1'b1) begin
                bad++;
                $display("FAIL hold%0d: v0=%b v1=%b r=%h r0=%b r1=%b busy=%b want %b %b %h 0 0 1",
                         h, bus.rsp0_valid, bus.rsp1_valid, bus.rsp_r, bus.req0_ready,
                         bus.req1_ready, bus.busy, ~win, win, er);
            end
        end

        bus.rsp0_ready = win ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.rsp1_ready = win ? 1'b1 : 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        total++;
        if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL release: v0=%b v1=%b busy=%b want 0 0 0",
                     bus.rsp0_valid, bus.rsp1_valid, bus.busy);
        end
    endtask

    task automatic test_single_add();
        do_txn(1, 0, 32'd5, 32'd7, 3'd0, '0, '0, 3'd0, 0, 0);
    endtask

    task automatic test_zero_flag();
        do_txn(0, 1, '0, '0, 3'd0, 32'd9, 32'd9, 3'd1, 1, 0);
    endtask

    task automatic test_tie();
        test_reset();
        for (int k = 0; k < 3; k++) begin
            do_txn(1, 1, 32'hF0, 32'h3C, 3'd2, 32'hF0, 32'h3C, 3'd3, 0, 1);
        end
        drive_idle();
    endtask

    task automatic test_backpressure();
        do_txn(1, 0, 32'd6, 32'd7, 3'd5, '0, '0, 3'd0, 4, 0);
    endtask

    task automatic test_divzero();
        do_txn(1, 0, 32'd10, 32'd0, 3'd6, '0, '0, 3'd0, 1, 0);
    endtask

    task automatic test_reset_mid_exec();
        bus.req0_valid = 1'b1; bus.req0_a = 32'd1; bus.req0_b = 32'd2; bus.req0_sel = 3'd0;
        #1;
        total++;
        if (bus.req0_ready !== 1'b1) begin
            bad++;
            $display("FAIL midrst_accept: ready0=%b want 1", bus.req0_ready);
        end
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0 ||
            bus.rsp_r !== '0) begin
            bad++;
            $display("FAIL midrst_now: busy=%b v0=%b v1=%b r=%h want 0 0 0 0",
                     bus.busy, bus.rsp0_valid, bus.rsp1_valid, bus.rsp_r);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_last = 1'b1;
        exp_q.delete();
        for (int i = 0; i < EC + 3; i++) begin
            @(posedge clk); #1;
            total++;
            if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0 || bus.busy !== 1'b0) begin
                bad++;
                $display("FAIL midrst_after%0d: v0=%b v1=%b busy=%b want 0 0 0",
                         i, bus.rsp0_valid, bus.rsp1_valid, bus.busy);
            end
        end
    endtask

    task automatic test_random();
        int mask;
        logic [W-1:0] a0, b0, a1, b1;
        logic [2:0] s0, s1;
        for (int n = 0; n < 40; n++) begin
            mask = $urandom_range(0, 4);
            if (mask == 0) begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
                #1;
                total++;
                if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 || bus.busy !== 1'b0) begin
                    bad++;
                    $display("FAIL idle_gap: r0=%b r1=%b busy=%b want 0 0 0",
                             bus.req0_ready, bus.req1_ready, bus.busy);
                end
                @(posedge clk); #1;
            end else begin
                a0 = $urandom; a1 = $urandom;
                b0 = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
                b1 = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
                s0 = 3'($urandom_range(0, 7));
                s1 = 3'($urandom_range(0, 7));
                do_txn(mask[0] || mask == 4, mask[1] || mask == 4, a0, b0, s0, a1, b1, s1,
                       $urandom_range(0, 3), 0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_add();
        test_zero_flag();
        test_tie();
        test_backpressure();
        test_divzero();
        test_reset_mid_exec();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
